mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  Memory stage between exe_stage and writeback. Holds one instruction per cycle-slot.
//  Waits for the data-cache response (data_ok) of a load or store issued by exe.
//  Aligns and extends load data, and forwards results and stall hints back to decode.
//  Buffers a response that arrives while writeback stalls. After a flush, it drops
//  responses that belong to cancelled requests.
// PARAMETERS
//  DISCARD_W  2  width of the cancelled-request counter; max outstanding discards = 2**DISCARD_W-1
// PORTS
//  clk               in   1   clock
//  reset             in   1   synchronous, active-high reset
//  ws_allowin        in   1   writeback can accept this cycle
//  ms_allowin        out  1   mem stage can accept from exe
//  es_to_ms_valid    in   1   exe presents a valid instruction
//  es_pc             in   32  instruction PC
//  es_result         in   32  ALU/CSR result; holds the data address for mem ops
//  es_dest           in   5   destination GPR
//  es_gr_we          in   1   GPR write enable
//  es_load_op        in   1   load instruction
//  es_store_op       in   1   store instruction
//  es_mem_size       in   2   [0]=byte, [1]=half, 00=word
//  es_mem_sign_exted in   1   sign-extend the load result
//  es_req_issued     in   1   exe handed a cache request to the cache with this entry
//  es_excp           in   1   entry carries an exception
//  data_data_ok      in   1   cache response pulse; responses return in order
//  data_rdata        in   32  cache read data, valid with data_data_ok
//  flush             in   1   pipeline flush (exception/ertn/refetch/idle)
//  ms_to_ws_valid    out  1   valid to writeback
//  ms_pc             out  32  PC to writeback
//  ms_final_result   out  32  aligned load data or es_result
//  ms_dest           out  5   destination to writeback
//  ms_gr_we          out  1   GPR write enable; low when ms_excp
//  ms_excp           out  1   exception flag to writeback
//  ms_flush          out  1   ms_valid & ms_excp; exe uses it to suppress new requests
//  ms_to_ds_forward_bus out 39 {dep_need_stall, forward_enable, dest[4:0], result[31:0]}
// BEHAVIOUR
//  Reset: ms_valid=0, state=EMPTY, discard_cnt=0, rdata_buf=0.
//   Hence ms_to_ws_valid=0, ms_flush=0, forward bus=0, ms_allowin=1.
//  Capture: when es_to_ms_valid && ms_allowin, latch all es_* fields. ms_valid<=1.
//  Entry state on capture:
//   WAIT if es_req_issued && !es_excp.
//   READY otherwise.
//  States per entry: EMPTY, WAIT, HOLD, READY.
//   WAIT  : accepted data_ok while discard_cnt==0.
//           If ws_allowin, the entry leaves with the live data_rdata.
//           Otherwise rdata_buf<=data_rdata and state goes to HOLD.
//   HOLD  : result comes from rdata_buf; leaves when ws_allowin.
//   READY : no cache wait; leaves when ws_allowin.
//  ms_ready_go = READY | HOLD | (WAIT & data_ok & discard_cnt==0).
//  ms_to_ws_valid = ms_valid & ms_ready_go. Zero cycles added when data_ok returns in the capture+1 cycle.
//  ms_allowin = (!ms_valid | ms_ready_go & ws_allowin) & (discard_cnt != 2**DISCARD_W-1).
//  Load alignment, using addr[1:0]=es_result[1:0]:
//   byte: select lane addr*8; half: select lane addr[1]*16; word: pass through.
//   Extend with the sign bit if es_mem_sign_exted, else with zeros.
//   Stores and non-mem entries output es_result.
//  Flush: ms_valid<=0 and state<=EMPTY next cycle.
//   Flush in WAIT with no accepted data_ok that cycle: discard_cnt increments.
//   Flush in WAIT with a same-cycle accepted data_ok: no increment.
//   Flush in HOLD or READY: no discard.
//  Discard: each data_ok while discard_cnt>0 decrements the counter. Its data is ignored; the stage state is unchanged.
//   Simultaneous increment and decrement leave the count unchanged.
//   The counter saturates, and ms_allowin blocks new entries while it is saturated.
//  Flush and capture in the same cycle: flush wins, nothing is captured.
//  Forward: forward_enable = ms_valid & ms_gr_we & (ms_dest!=0).
//   dep_need_stall = ms_valid & es_load_op_latched & !ms_ready_go.
//   The result field carries ms_final_result.
//  Reset mid-operation clears discard_cnt. The cache is reset in the same cycle, so it produces no stale data_ok.
// TESTING
//  Load of byte 0x80 at addr 0x..3 (sign-extended), rdata=0x80112233, data_ok 1 cycle later
//   -> ms_final_result=0xFFFFFF80, ms_to_ws_valid for 1 cycle.
//  Load of a half at addr 0x..2 (zero-extended), rdata=0xBEEF0000, ws_allowin=0 for 3 cycles
//   -> HOLD; the stage outputs 0x0000BEEF when ws_allowin rises; dep_need_stall=0 while in HOLD.
//  Load in WAIT, then flush, then data_ok 2 cycles later; a new load enters and gets its own data_ok
//   -> first data discarded; discard_cnt 1->0; the second load receives the second rdata only.
//  Three back-to-back flushed loads with DISCARD_W=2
//   -> discard_cnt reaches 3; ms_allowin=0 until the next data_ok.
//  Entry with es_excp=1 and es_req_issued=0
//   -> passes in 1 cycle; ms_flush=1; ms_gr_we=0; no data_ok required.
//  Flush in the same cycle as the data_ok of the waiting load
//   -> discard_cnt stays 0; the next load consumes the next data_ok.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory access stage: waits for the data-cache response, aligns load data, buffers
// a response while writeback stalls, and drops responses of flushed requests.
module mem_access_stage #(
  parameter int unsigned DISCARD_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_allowin,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [31:0] es_pc,
  input  logic [31:0] es_result,
  input  logic [4:0]  es_dest,
  input  logic        es_gr_we,
  input  logic        es_load_op,
  input  logic        es_store_op,
  input  logic [1:0]  es_mem_size,
  input  logic        es_mem_sign_exted,
  input  logic        es_req_issued,
  input  logic        es_excp,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  input  logic        flush,
  output logic        ms_to_ws_valid,
  output logic [31:0] ms_pc,
  output logic [31:0] ms_final_result,
  output logic [4:0]  ms_dest,
  output logic        ms_gr_we,
  output logic        ms_excp,
  output logic        ms_flush,
  output logic [38:0] ms_to_ds_forward_bus
);

  typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_HOLD, ST_READY} state_e;

  state_e                 state_q, state_d;
  logic                   ms_valid_q, ms_valid_d;
  logic [31:0]            pc_q, pc_d;
  logic [31:0]            result_q, result_d;
  logic [4:0]             dest_q, dest_d;
  logic                   gr_we_q, gr_we_d;
  logic                   load_op_q, load_op_d;
  logic [1:0]             mem_size_q, mem_size_d;
  logic                   sign_q, sign_d;
  logic                   excp_q, excp_d;
  logic [DISCARD_W-1:0]   discard_cnt_q, discard_cnt_d;
  logic [31:0]            rdata_buf_q, rdata_buf_d;

  logic        cnt_zero, cnt_sat, data_ok_acc, discard_inc, discard_dec;
  logic        ms_ready_go;
  logic [31:0] raw_data, load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        forward_enable, dep_need_stall;
  logic        unused_store_op;

  // Store vs. non-mem entries are indistinguishable on the result path.
  assign unused_store_op = es_store_op;

  assign cnt_zero    = (discard_cnt_q == '0);
  assign cnt_sat     = (discard_cnt_q == '1);
  assign data_ok_acc = data_data_ok & cnt_zero;
  assign discard_dec = data_data_ok & ~cnt_zero;
  assign discard_inc = flush & ms_valid_q & (state_q == ST_WAIT) & ~data_ok_acc;

  assign ms_ready_go    = (state_q == ST_READY) | (state_q == ST_HOLD)
                        | ((state_q == ST_WAIT) & data_ok_acc);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
  assign ms_allowin     = (~ms_valid_q | (ms_ready_go & ws_allowin)) & ~cnt_sat;

  // Load alignment: byte lane by addr[1:0], half lane by addr[1].
  always_comb begin
    raw_data = (state_q == ST_HOLD) ? rdata_buf_q : data_rdata;
    case (result_q[1:0])
      2'd0:    byte_sel = raw_data[7:0];
      2'd1:    byte_sel = raw_data[15:8];
      2'd2:    byte_sel = raw_data[23:16];
      default: byte_sel = raw_data[31:24];
    endcase
    half_sel = result_q[1] ? raw_data[31:16] : raw_data[15:0];
    if (mem_size_q[0]) begin
      load_data = {{24{sign_q & byte_sel[7]}}, byte_sel};
    end else if (mem_size_q[1]) begin
      load_data = {{16{sign_q & half_sel[15]}}, half_sel};
    end else begin
      load_data = raw_data;
    end
  end

  assign ms_final_result = load_op_q ? load_data : result_q;
  assign ms_pc           = pc_q;
  assign ms_dest         = dest_q;
  assign ms_gr_we        = gr_we_q & ~excp_q;
  assign ms_excp         = excp_q;
  assign ms_flush        = ms_valid_q & excp_q;

  assign forward_enable       = ms_valid_q & ms_gr_we & (dest_q != 5'd0);
  assign dep_need_stall       = ms_valid_q & load_op_q & ~ms_ready_go;
  assign ms_to_ds_forward_bus = {dep_need_stall, forward_enable, dest_q, ms_final_result};

  // Next entry state; flush beats capture, capture covers the leave-and-refill case.
  always_comb begin
    state_d     = state_q;
    ms_valid_d  = ms_valid_q;
    pc_d        = pc_q;
    result_d    = result_q;
    dest_d      = dest_q;
    gr_we_d     = gr_we_q;
    load_op_d   = load_op_q;
    mem_size_d  = mem_size_q;
    sign_d      = sign_q;
    excp_d      = excp_q;
    rdata_buf_d = rdata_buf_q;
    if (flush) begin
      ms_valid_d = 1'b0;
      state_d    = ST_EMPTY;
    end else if (es_to_ms_valid && ms_allowin) begin
      ms_valid_d = 1'b1;
      state_d    = (es_req_issued && !es_excp) ? ST_WAIT : ST_READY;
      pc_d       = es_pc;
      result_d   = es_result;
      dest_d     = es_dest;
      gr_we_d    = es_gr_we;
      load_op_d  = es_load_op;
      mem_size_d = es_mem_size;
      sign_d     = es_mem_sign_exted;
      excp_d     = es_excp;
    end else if (ms_to_ws_valid && ws_allowin) begin
      ms_valid_d = 1'b0;
      state_d    = ST_EMPTY;
    end else if (ms_valid_q && (state_q == ST_WAIT) && data_ok_acc) begin
      rdata_buf_d = data_rdata;
      state_d     = ST_HOLD;
    end
  end

  // Outstanding cancelled-request count, saturating.
  always_comb begin
    discard_cnt_d = discard_cnt_q;
    if (discard_inc && !discard_dec && !cnt_sat) begin
      discard_cnt_d = discard_cnt_q + DISCARD_W'(1);
    end else if (discard_dec && !discard_inc) begin
      discard_cnt_d = discard_cnt_q - DISCARD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_EMPTY;
      ms_valid_q    <= 1'b0;
      pc_q          <= '0;
      result_q      <= '0;
      dest_q        <= '0;
      gr_we_q       <= 1'b0;
      load_op_q     <= 1'b0;
      mem_size_q    <= '0;
      sign_q        <= 1'b0;
      excp_q        <= 1'b0;
      discard_cnt_q <= '0;
      rdata_buf_q   <= '0;
    end else begin
      state_q       <= state_d;
      ms_valid_q    <= ms_valid_d;
      pc_q          <= pc_d;
      result_q      <= result_d;
      dest_q        <= dest_d;
      gr_we_q       <= gr_we_d;
      load_op_q     <= load_op_d;
      mem_size_q    <= mem_size_d;
      sign_q        <= sign_d;
      excp_q        <= excp_d;
      discard_cnt_q <= discard_cnt_d;
      rdata_buf_q   <= rdata_buf_d;
    end
  end

endmodule
